// File: rtl/axi_mem_arbiter.sv
// Purpose: two-master AXI4 arbiter sharing one LiteDRAM slave port; AXI_ARB_FIXED_PRIO_EN selects strict master-0 priority instead of round-robin.
// Latency: grant registered one cycle after request; payload, valid and ready pass combinationally once granted.
// Backpressure: slave readies route straight to the granted master; the other master sees every valid/ready low.
module axi_mem_arbiter #(
  parameter int ID_W   = 6,
  parameter int ADDR_W = 27,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rstn,
  // master 0
  input  logic [ID_W-1:0]     m0_awid,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic [7:0]          m0_awlen,
  input  logic [2:0]          m0_awsize,
  input  logic [1:0]          m0_awburst,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wlast,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [ID_W-1:0]     m0_bid,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  input  logic [ID_W-1:0]     m0_arid,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [7:0]          m0_arlen,
  input  logic [2:0]          m0_arsize,
  input  logic [1:0]          m0_arburst,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [ID_W-1:0]     m0_rid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rlast,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  // master 1
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [7:0]          m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wlast,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [ID_W-1:0]     m1_bid,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  input  logic [ID_W-1:0]     m1_arid,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [7:0]          m1_arlen,
  input  logic [2:0]          m1_arsize,
  input  logic [1:0]          m1_arburst,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [ID_W-1:0]     m1_rid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rlast,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  // slave (LiteDRAM)
  output logic [ID_W-1:0]     s_awid,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wlast,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [ID_W-1:0]     s_bid,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic [ID_W-1:0]     s_arid,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [ID_W-1:0]     s_rid,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rlast,
  input  logic                s_rvalid,
  output logic                s_rready
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;
  logic     w_gnt, w_gnt_nxt;   // 0 = master 0, 1 = master 1
  logic     r_gnt, r_gnt_nxt;
  logic     w_pick, r_pick;     // winner if a grant were taken this cycle
  logic     w_req, r_req;

  assign w_req = m0_awvalid | m1_awvalid;
  assign r_req = m0_arvalid | m1_arvalid;

`ifdef AXI_ARB_FIXED_PRIO_EN
  // Strict priority: master 1 only wins when master 0 is not asking.
  always_comb begin
    w_pick = ~m0_awvalid;
    r_pick = ~m0_arvalid;
  end
`else
  logic w_ptr, r_ptr;           // last granted master per direction

  // Round-robin pick: on a tie favour the master that did not win last; a lone request always wins.
  always_comb begin
    w_pick = (m0_awvalid && m1_awvalid) ? ~w_ptr : m1_awvalid;
    r_pick = (m0_arvalid && m1_arvalid) ? ~r_ptr : m1_arvalid;
  end

  // Pointers move at grant time; reset to master 1 so master 0 takes the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_ptr <= 1'b1;
      r_ptr <= 1'b1;
    end else begin
      if (w_state == W_IDLE && w_req) w_ptr <= w_pick;
      if (r_state == R_IDLE && r_req) r_ptr <= r_pick;
    end
  end
`endif

  // State and grant registers; reset parks both directions idle on master 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      w_gnt   <= 1'b0;
      r_gnt   <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
      w_gnt   <= w_gnt_nxt;
      r_gnt   <= r_gnt_nxt;
    end
  end

  // Write direction: grant, address handshake, data until wlast, response.
  always_comb begin
    w_state_nxt = w_state;
    w_gnt_nxt   = w_gnt;
    case (w_state)
      W_IDLE: if (w_req) begin
        w_gnt_nxt   = w_pick;
        w_state_nxt = W_ADDR;
      end
      W_ADDR: if (s_awvalid && s_awready) w_state_nxt = W_DATA;
      W_DATA: if (s_wvalid && s_wready && s_wlast) w_state_nxt = W_RESP;
      W_RESP: if (s_bvalid && s_bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Read direction: grant, address handshake, data until last beat.
  always_comb begin
    r_state_nxt = r_state;
    r_gnt_nxt   = r_gnt;
    case (r_state)
      R_IDLE: if (r_req) begin
        r_gnt_nxt   = r_pick;
        r_state_nxt = R_ADDR;
      end
      R_ADDR: if (s_arvalid && s_arready) r_state_nxt = R_DATA;
      R_DATA: if (s_rvalid && s_rready && s_rlast) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  logic w_addr_st, w_data_st, w_resp_st, r_addr_st, r_data_st;
  assign w_addr_st = (w_state == W_ADDR);
  assign w_data_st = (w_state == W_DATA);
  assign w_resp_st = (w_state == W_RESP);
  assign r_addr_st = (r_state == R_ADDR);
  assign r_data_st = (r_state == R_DATA);

  // Handshake steering: only the phase's granted master sees the slave's valid/ready.
  assign s_awvalid  = w_addr_st & (w_gnt ? m1_awvalid : m0_awvalid);
  assign m0_awready = w_addr_st & ~w_gnt & s_awready;
  assign m1_awready = w_addr_st &  w_gnt & s_awready;
  assign s_wvalid   = w_data_st & (w_gnt ? m1_wvalid : m0_wvalid);
  assign m0_wready  = w_data_st & ~w_gnt & s_wready;
  assign m1_wready  = w_data_st &  w_gnt & s_wready;
  assign s_bready   = w_resp_st & (w_gnt ? m1_bready : m0_bready);
  assign m0_bvalid  = w_resp_st & ~w_gnt & s_bvalid;
  assign m1_bvalid  = w_resp_st &  w_gnt & s_bvalid;
  assign s_arvalid  = r_addr_st & (r_gnt ? m1_arvalid : m0_arvalid);
  assign m0_arready = r_addr_st & ~r_gnt & s_arready;
  assign m1_arready = r_addr_st &  r_gnt & s_arready;
  assign s_rready   = r_data_st & (r_gnt ? m1_rready : m0_rready);
  assign m0_rvalid  = r_data_st & ~r_gnt & s_rvalid;
  assign m1_rvalid  = r_data_st &  r_gnt & s_rvalid;

  // Payload muxes toward the slave, selected by the registered grants.
  assign s_awid    = w_gnt ? m1_awid    : m0_awid;
  assign s_awaddr  = w_gnt ? m1_awaddr  : m0_awaddr;
  assign s_awlen   = w_gnt ? m1_awlen   : m0_awlen;
  assign s_awsize  = w_gnt ? m1_awsize  : m0_awsize;
  assign s_awburst = w_gnt ? m1_awburst : m0_awburst;
  assign s_wdata   = w_gnt ? m1_wdata   : m0_wdata;
  assign s_wstrb   = w_gnt ? m1_wstrb   : m0_wstrb;
  assign s_wlast   = w_gnt ? m1_wlast   : m0_wlast;
  assign s_arid    = r_gnt ? m1_arid    : m0_arid;
  assign s_araddr  = r_gnt ? m1_araddr  : m0_araddr;
  assign s_arlen   = r_gnt ? m1_arlen   : m0_arlen;
  assign s_arsize  = r_gnt ? m1_arsize  : m0_arsize;
  assign s_arburst = r_gnt ? m1_arburst : m0_arburst;

  // Response payloads fan out to both masters; the gated valids decide who consumes them.
  assign m0_bid   = s_bid;
  assign m0_bresp = s_bresp;
  assign m1_bid   = s_bid;
  assign m1_bresp = s_bresp;
  assign m0_rid   = s_rid;
  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m0_rlast = s_rlast;
  assign m1_rid   = s_rid;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_rlast = s_rlast;

endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

Two-master AXI4 arbiter that shares the single LiteDRAM AXI slave port (27-bit address, 64-bit data, 6-bit ID) between the CPU path, after its clock-domain crossing, and a second requester such as a DMA or debug loader. It sits in the user-clock domain between the CDC output and the DDR2 controller. Read and write directions are arbitrated independently. Each direction allows one outstanding burst.

## Interface
- ID_W, 6, AXI ID width; passed through unchanged.
- ADDR_W, 27, AXI address width; passed through unchanged.
- DATA_W, 64, AXI data width; the strobe width is DATA_W/8.
- clk  in  1  user clock; all logic is on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- m0_aw{id,addr,len,size,burst,valid}  in  ID_W/ADDR_W/8/3/2/1  master 0 write address.
- m0_awready  out  1  write address ready to master 0.
- m0_w{data,strb,last,valid}  in  DATA_W/DATA_W/8/1/1  master 0 write data.
- m0_wready  out  1  write data ready to master 0.
- m0_b{id,resp,valid}  out  ID_W/2/1  write response to master 0.
- m0_bready  in  1  write response ready from master 0.
- m0_ar{id,addr,len,size,burst,valid}  in  ID_W/ADDR_W/8/3/2/1  master 0 read address.
- m0_arready  out  1  read address ready to master 0.
- m0_r{id,data,resp,last,valid}  out  ID_W/DATA_W/2/1/1  read data to master 0.
- m0_rready  in  1  read data ready from master 0.
- m1_*: identical set for master 1.
- s_*: the mirror set toward LiteDRAM, with directions inverted.

## Operation
- Write FSM states are W_IDLE, W_ADDR, W_DATA and W_RESP.
  - W_IDLE: if any m*_awvalid is high, register the grant and go to W_ADDR.
  - W_ADDR: forward the granted master's AW to s_aw*. On the s_awvalid&s_awready handshake, go to W_DATA.
  - W_DATA: route the granted master's W channel both ways. On a beat with wlast, go to W_RESP.
  - W_RESP: route s_b* to the granted master and s_bready from it. On the B handshake, go to W_IDLE.
- Read FSM states are R_IDLE, R_ADDR and R_DATA.
  - R_IDLE and R_ADDR behave the same way for the AR channel.
  - R_DATA: route s_r* to the granted master. On an R handshake with rlast, go to R_IDLE.
- The non-granted master sees every ready low and every valid low, always.
- Round-robin arbitration:
  - Each direction keeps a last-grant pointer; reset value is master 1, so master 0 wins the first tie.
  - On simultaneous requests, grant the master that is not the pointer.
  - A lone request is granted regardless of the pointer.
  - The pointer is updated at grant time.
- Read and write FSMs are fully independent. A read and a write may proceed at once, from the same or different masters.
- W beats presented before their AW are not accepted until W_DATA; wready stays low.
- Payload fields are routed combinationally by a registered grant select. No field is modified.
- Downstream ordering is preserved trivially, because each direction has only one outstanding burst.

## Timing
- Reset values:
  - All FSMs in IDLE; pointers at master 1.
  - Every valid and ready output is 0: s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready, m*_awready, m*_wready, m*_bvalid, m*_arready, m*_rvalid.
  - Payload outputs are don't-care; they drive master 0's fields.
- Arbitration latency:
  - Request in cycle N gives s_awvalid/s_arvalid high in cycle N+1.
  - The master's handshake completes in the same cycle as the slave's, via combinational ready passthrough.
- Release takes 1 cycle. After the final B or last R handshake in cycle N, the FSM is IDLE in N+1, and the next grant drives valid at N+2 at the earliest.
- A master must hold AW/AR valid and stable until ready (AXI rule). The arbiter never drops a granted valid.
- If rstn is asserted mid-burst, all state clears immediately and outputs go to their reset values. LiteDRAM and the masters are reset by the same event; no burst is resumed.
- len=0 (single beat) is legal: W_DATA exits on the first beat, since wlast=1.

## Configuration
- AXI_ARB_FIXED_PRIO_EN:
  - Defined: both directions use strict priority; master 0 always wins simultaneous requests and the pointers are not implemented.
  - Undefined (default): round-robin as described above.

## Test plan
- Only m0 writes awaddr=0x0000100, len=3, 4 beats -> s_awvalid 1 cycle after the request, 4 beats reach the slave, m0 receives bresp=0 with bid echoed, and the FSM is in W_IDLE 1 cycle after the B handshake.
- m0 and m1 raise arvalid in the same cycle, repeated 4 times -> grants go m0, m1, m0, m1. With AXI_ARB_FIXED_PRIO_EN defined, all four go to m0 first.
- m0 write burst (len=7) overlapped with an m1 read (len=7) -> both complete and data is correct. The slave sees concurrent AW and AR with no cross-routing of B or R.
- m1 presents wvalid with data 0xDEADBEEF_CAFEF00D before awvalid -> m1_wready stays 0 until the AW handshake, then the beat is accepted.
- Slave holds rready-stall patterns and rvalid gaps on a len=15 read -> exactly 16 beats reach the granted master, rlast is on the 16th, and the other master's rvalid stays 0 throughout.
- rstn pulsed low during W_DATA beat 2 of 8 -> all valid and ready outputs are 0 within the reset, and after release a new m1 write is granted first.
